demux_frame_sequencer: RTL
==========================

Name: demux_frame_sequencer

Overview:
- Upstream control stage for the one-bit 1:4 demultiplexer.
- Receives a qualified serial bit stream framed as a 2-bit channel header followed by a fixed-length payload.
- Drives the demux data input and select lines so each payload bit reaches the addressed output (out1..out4).
- Holds the data line low outside payload so all demux outputs stay 0 between frames.

Parameters:
- PAYLOAD_LEN, 8, payload bits per frame; legal range 1..256.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_bit  input  1  serial stream bit, sampled only when in_valid=1
- in_valid  input  1  qualifies in_bit this cycle
- abort  input  1  synchronous frame abort
- a  output  1  data to demux input a; registered
- s1  output  1  select MSB to demux s1; registered
- s0  output  1  select LSB to demux s0; registered
- payload_valid  output  1  a carries a payload bit this cycle
- frame_done  output  1  one-cycle pulse, coincident with the last payload bit on a
- busy  output  1  high in HDR or PAY state

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State=IDLE, bit counter=0, header capture register=0.
  - a, s0, s1, payload_valid, frame_done, busy all 0.
  - Release is synchronous to the next clk edge.
- Frame format on valid bits: bit0 = channel MSB, bit1 = channel LSB, then PAYLOAD_LEN payload bits. Channel 0..3 maps to out1..out4.
- Cycles with in_valid=0 are ignored in every state; no state, counter or select change. Gaps may occur anywhere in a frame.
- IDLE:
  - On in_valid, capture in_bit as pending MSB and go to HDR.
- HDR:
  - On in_valid, load s1<=pending MSB and s0<=in_bit simultaneously, clear counter, go to PAY.
  - New select values are visible the cycle after the second header bit, before any payload bit reaches a.
- PAY:
  - On in_valid, next cycle a<=in_bit and payload_valid<=1, and counter increments.
  - On the cycle in_valid=0, next cycle a<=0 and payload_valid<=0.
  - When the accepted bit is number PAYLOAD_LEN (counter==PAYLOAD_LEN-1), frame_done<=1 alongside that bit and state<=IDLE.
  - A valid bit on the very next cycle starts a new header; back-to-back frames have no dead cycle.
- Latency: one cycle from accepted payload bit to a/payload_valid.
- a is forced to 0 whenever payload_valid=0.
- s0/s1 hold the last frame's channel through IDLE and the next HDR. They change only at header completion, so select never changes while payload_valid=1.
- busy=1 in HDR and PAY; 0 in IDLE, including the cycle after the final bit is accepted.
- abort=1:
  - Next state is IDLE, counter cleared, and a, payload_valid, frame_done are 0 next cycle.
  - s0/s1 are retained and the partial frame is discarded.
  - abort has priority over in_valid in the same cycle; that bit is dropped.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost and no frame_done is generated.
- PAYLOAD_LEN=1: a single payload bit produces payload_valid and frame_done in the same cycle.
- Counter width is fixed at 8 bits; it never wraps within legal PAYLOAD_LEN.

Test Plan:
- Reset then continuous valid stream 1,0,10110011 (PAYLOAD_LEN=8) -> s1=1, s0=0 the cycle after header; a=1,0,1,1,0,0,1,1 on 8 consecutive cycles with payload_valid=1; frame_done only with the final 1; busy drops after.
- Same frame with in_valid=0 gaps inserted after header bit 0 and after payload bit 3 -> identical a sequence, payload_valid=0 and a=0 during gap cycles, no select change.
- Back-to-back frames to channel 3 then channel 0 -> s1s0=11 throughout first payload, 00 throughout second; no cycle with payload_valid=1 under a mixed select.
- abort asserted together with payload bit 4 -> that bit not output, payload_valid=0 next cycle, no frame_done; next frame decodes correctly from IDLE.
- reset_n pulsed low mid-payload, asynchronously between edges -> all outputs 0 immediately; after release a fresh frame to channel 2 gives s1s0=10 and full payload.
- PAYLOAD_LEN=1 build, stream 0,1,1 -> s1s0=01, single cycle with a=1, payload_valid=1, frame_done=1.

Source files
------------

// File: rtl/demux_frame_sequencer.sv
// Frame sequencer that feeds a one-bit 1:4 demux.
// It decodes a 2-bit channel header, then steers PAYLOAD_LEN serial bits onto a, s1 and s0.
module demux_frame_sequencer #(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  input  logic in_valid,
  input  logic abort,
  output logic a,
  output logic s1,
  output logic s0,
  output logic payload_valid,
  output logic frame_done,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    PAY  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(PAYLOAD_LEN - 1);

  state_t     state_r;
  logic [7:0] cnt_r;
  logic       msb_r;

  // Frame FSM with registered demux data, select and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      cnt_r         <= 8'd0;
      msb_r         <= 1'b0;
      a             <= 1'b0;
      s1            <= 1'b0;
      s0            <= 1'b0;
      payload_valid <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      // Data and strobes default low, so a stays 0 outside accepted payload bits
      a             <= 1'b0;
      payload_valid <= 1'b0;
      frame_done    <= 1'b0;
      if (abort) begin
        state_r <= IDLE;
        cnt_r   <= 8'd0;
        busy    <= 1'b0;
      end else if (in_valid) begin
        case (state_r)
          IDLE: begin
            msb_r   <= in_bit;
            state_r <= HDR;
            busy    <= 1'b1;
          end
          HDR: begin
            s1      <= msb_r;
            s0      <= in_bit;
            cnt_r   <= 8'd0;
            state_r <= PAY;
            busy    <= 1'b1;
          end
          PAY: begin
            a             <= in_bit;
            payload_valid <= 1'b1;
            if (cnt_r == LAST_IDX) begin
              frame_done <= 1'b1;
              cnt_r      <= 8'd0;
              state_r    <= IDLE;
              busy       <= 1'b0;
            end else begin
              cnt_r   <= cnt_r + 8'd1;
              state_r <= PAY;
              busy    <= 1'b1;
            end
          end
          default: begin
            cnt_r   <= 8'd0;
            state_r <= IDLE;
            busy    <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
        cnt_r   <= cnt_r;
        busy    <= busy;
      end
    end
  end

endmodule
